// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges single-cycle ALU results and FIFO-buffered memory results onto the register file write port.
module writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [ADDR_WIDTH-1:0]         alu_addr,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          write_enable,
  output logic [ADDR_WIDTH-1:0]         write_addr,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [2**ADDR_WIDTH-1:0]      busy_mask,
  output logic [$clog2(DEPTH):0]        fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      vld;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop;
  logic                  head_drop, alu_drop;
  assign mem_ready = fifo_count < CW'(DEPTH);
  assign push = mem_valid && mem_ready;
  assign pop = !alu_valid && fifo_count != '0;
  assign head_drop = DROP_R0 && addr_q[rd_ptr] == '0;
  assign alu_drop = DROP_R0 && alu_addr == '0;
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i]) busy_mask[addr_q[i]] = 1'b1;
    if (DROP_R0) busy_mask[0] = 1'b0;
  end
  // Payload storage needs no reset; per-slot valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= mem_addr;
      data_q[wr_ptr] <= mem_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      vld          <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (pop) vld[rd_ptr] <= 1'b0;
      if (push) vld[wr_ptr] <= 1'b1;
      if (alu_valid) begin
        write_enable <= !alu_drop;
        write_addr   <= alu_addr;
        write_data   <= alu_data;
      end else if (pop) begin
        write_enable <= !head_drop;
        write_addr   <= addr_q[rd_ptr];
        write_data   <= data_q[rd_ptr];
      end else begin
        write_enable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed scenarios plus a cycle scoreboard of the write port, FIFO occupancy and busy mask.
module tb_writeback_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          mem_valid = 1'b0;
  logic          mem_ready;
  logic [AW-1:0] mem_addr = '0;
  logic [DW-1:0] mem_data = '0;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [31:0]   busy_mask;
  logic [2:0]    fifo_count;
  int            total = 0;
  int            passed = 0;
  bit            mon_en = 1'b0;
  logic [AW+DW-1:0] mq[$];
  logic [AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  writeback_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .busy_mask(busy_mask), .fifo_count(fifo_count)
  );

  // Reference model: accepted memory results queue in mq; each expected register write is pushed to exp_q.
  always @(posedge clk) begin
    if (rst_n) begin : model
      logic acc;
      logic [AW+DW-1:0] e;
      acc = mem_valid && mq.size() < DEPTH;
      if (alu_valid) begin
        if (alu_addr != '0) exp_q.push_back({alu_addr, alu_data});
      end else if (mq.size() != 0) begin
        e = mq.pop_front();
        if (e[AW+DW-1:DW] != '0) exp_q.push_back(e);
      end
      if (acc) mq.push_back({mem_addr, mem_data});
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    exp_q.delete();
  end

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i][AW+DW-1:DW]] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst_n && mon_en) begin : mon
      logic [AW+DW-1:0] e;
      logic exp_we;
      exp_we = exp_q.size() != 0;
      total++;
      if (write_enable !== exp_we) begin
        $display("FAIL sb_enable got %b exp %b at %0t", write_enable, exp_we, $time);
        exp_q.delete();
      end else if (exp_we) begin
        e = exp_q.pop_front();
        if ({write_addr, write_data} !== e)
          $display("FAIL sb_write got %h/%h exp %h/%h", write_addr, write_data, e[AW+DW-1:DW], e[DW-1:0]);
        else passed++;
      end else passed++;
      total++;
      if (fifo_count !== 3'(mq.size())) $display("FAIL sb_count got %0d exp %0d", fifo_count, mq.size());
      else passed++;
      total++;
      if (mem_ready !== (mq.size() < DEPTH)) $display("FAIL sb_ready got %b exp %b", mem_ready, mq.size() < DEPTH);
      else passed++;
      total++;
      if (busy_mask !== model_busy()) $display("FAIL sb_busy got %h exp %h", busy_mask, model_busy());
      else passed++;
    end
  end

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #12;
    total++; if (write_enable !== 1'b0) $display("FAIL reset_we got %b exp 0", write_enable); else passed++;
    total++; if (write_addr !== '0) $display("FAIL reset_addr got %h exp 0", write_addr); else passed++;
    total++; if (write_data !== '0) $display("FAIL reset_data got %h exp 0", write_data); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", fifo_count); else passed++;
    total++; if (busy_mask !== '0) $display("FAIL reset_busy got %h exp 0", busy_mask); else passed++;
    total++; if (mem_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", mem_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1234;
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if (write_enable !== 1'b1) $display("FAIL alu_we got %b exp 1", write_enable); else passed++;
    total++; if (write_addr !== 5'd3) $display("FAIL alu_addr got %0d exp 3", write_addr); else passed++;
    total++; if (write_data !== 32'h1234) $display("FAIL alu_data got %h exp 1234", write_data); else passed++;
    @(negedge clk);
    total++; if (write_enable !== 1'b0) $display("FAIL alu_we_off got %b exp 0", write_enable); else passed++;
  endtask

  task automatic test_mem();
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hDEADBEEF;
    @(negedge clk);
    mem_valid = 1'b0;
    total++; if (busy_mask[7] !== 1'b1) $display("FAIL mem_busy7 got %b exp 1", busy_mask[7]); else passed++;
    total++; if (fifo_count !== 3'd1) $display("FAIL mem_count got %0d exp 1", fifo_count); else passed++;
    total++; if (write_enable !== 1'b0) $display("FAIL mem_no_bypass got %b exp 0", write_enable); else passed++;
    @(negedge clk);
    total++; if (write_enable !== 1'b1 || write_addr !== 5'd7) $display("FAIL mem_write got %b/%0d exp 1/7", write_enable, write_addr); else passed++;
    total++; if (write_data !== 32'hDEADBEEF) $display("FAIL mem_data got %h exp deadbeef", write_data); else passed++;
    total++; if (busy_mask !== '0) $display("FAIL mem_busy_clear got %h exp 0", busy_mask); else passed++;
  endtask

  task automatic test_priority();
    int k;
    logic acc;
    k = 0;
    for (int c = 0; c < 11; c++) begin
      alu_valid = c < 6; alu_addr = 5'(20 + c); alu_data = 32'hC0DE_0000 + 32'(c);
      mem_valid = k < 5; mem_addr = 5'(k + 1); mem_data = 32'hA000_0000 + 32'(k + 1);
      acc = mem_valid && mem_ready;
      @(negedge clk);
      if (acc) k++;
      if (c < 6) begin
        total++;
        if (write_enable !== 1'b1 || write_addr !== 5'(20 + c))
          $display("FAIL prio_alu c=%0d got %b/%0d exp 1/%0d", c, write_enable, write_addr, 20 + c);
        else passed++;
      end
      if (c >= 3 && c < 6) begin
        total++; if (mem_ready !== 1'b0) $display("FAIL prio_backpressure c=%0d got %b exp 0", c, mem_ready); else passed++;
      end
      if (c >= 6) begin
        total++;
        if (write_enable !== 1'b1 || write_addr !== 5'(c - 5))
          $display("FAIL prio_drain c=%0d got %b/%0d exp 1/%0d", c, write_enable, write_addr, c - 5);
        else passed++;
      end
    end
    idle();
    total++; if (k !== 5) $display("FAIL prio_accepts got %0d exp 5", k); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL prio_empty got %0d exp 0", fifo_count); else passed++;
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd16; alu_data = 32'(i);
      mem_valid = 1'b1; mem_addr = 5'(8 + i); mem_data = 32'hB000_0000 + 32'(i);
      @(negedge clk);
    end
    total++; if (fifo_count !== 3'd4 || mem_ready !== 1'b0) $display("FAIL full_state got %0d/%b exp 4/0", fifo_count, mem_ready); else passed++;
    alu_valid = 1'b0; mem_addr = 5'd12; mem_data = 32'hB000_0004;
    @(negedge clk);
    total++; if (write_enable !== 1'b1 || write_addr !== 5'd8) $display("FAIL full_deq got %b/%0d exp 1/8", write_enable, write_addr); else passed++;
    total++; if (fifo_count !== 3'd3 || mem_ready !== 1'b1) $display("FAIL full_no_enq got %0d/%b exp 3/1", fifo_count, mem_ready); else passed++;
    alu_valid = 1'b1; alu_addr = 5'd17;
    @(negedge clk);
    idle();
    total++; if (fifo_count !== 3'd4 || mem_ready !== 1'b0) $display("FAIL full_reenq got %0d/%b exp 4/0", fifo_count, mem_ready); else passed++;
    repeat (4) @(negedge clk);
    total++; if (write_addr !== 5'd12 || write_data !== 32'hB000_0004) $display("FAIL full_last got %0d/%h exp 12/b0000004", write_addr, write_data); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL full_drained got %0d exp 0", fifo_count); else passed++;
  endtask

  task automatic test_drop_r0();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
    @(negedge clk);
    alu_valid = 1'b0;
    total++; if (write_enable !== 1'b0) $display("FAIL drop_alu got %b exp 0", write_enable); else passed++;
    alu_valid = 1'b1; alu_addr = 5'd6; alu_data = 32'h66;
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h77;
    @(negedge clk);
    idle();
    total++; if (fifo_count !== 3'd1 || busy_mask[0] !== 1'b0) $display("FAIL drop_queued got %0d/%b exp 1/0", fifo_count, busy_mask[0]); else passed++;
    @(negedge clk);
    total++; if (fifo_count !== 3'd0 || write_enable !== 1'b0) $display("FAIL drop_deq got %0d/%b exp 0/0", fifo_count, write_enable); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = 5'd18; alu_data = 32'(i);
      mem_valid = 1'b1; mem_addr = 5'(13 + i); mem_data = 32'hE000_0000 + 32'(i);
      @(negedge clk);
    end
    idle();
    total++; if (fifo_count !== 3'd3) $display("FAIL arst_fill got %0d exp 3", fifo_count); else passed++;
    @(negedge clk);
    total++; if (write_enable !== 1'b1 || write_addr !== 5'd13) $display("FAIL arst_drain got %b/%0d exp 1/13", write_enable, write_addr); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (write_enable !== 1'b0 || write_addr !== '0 || write_data !== '0) $display("FAIL arst_port got %b/%0d/%h exp 0/0/0", write_enable, write_addr, write_data); else passed++;
    total++; if (fifo_count !== 3'd0 || busy_mask !== '0 || mem_ready !== 1'b1) $display("FAIL arst_fifo got %0d/%h/%b exp 0/0/1", fifo_count, busy_mask, mem_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (write_enable !== 1'b0 || fifo_count !== 3'd0) $display("FAIL arst_stale got %b/%0d exp 0/0", write_enable, fifo_count); else passed++;
    repeat (3) @(negedge clk);
    total++; if (write_enable !== 1'b0) $display("FAIL arst_quiet got %b exp 0", write_enable); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_priority();
    test_full_simul();
    test_drop_r0();
    test_async_reset();
    mon_en = 1'b0;
    total++; if (exp_q.size() != 0) $display("FAIL sb_leftover got %0d exp 0", exp_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Write-back stage directly upstream of the 32x32 register file; sole driver of its single write port (write_enable, write_addr, write_data).
- Merges two result sources:
  - ALU: single-cycle, always accepted, highest priority.
  - Memory/long-latency unit: valid/ready handshake, buffered in a DEPTH-entry FIFO.
- Exports a per-register busy mask so the hazard unit can stall reads of registers with queued writes.

Parameters:
- DATA_WIDTH, 32, width of result data.
- ADDR_WIDTH, 5, register address width; register count = 2**ADDR_WIDTH.
- DEPTH, 4, memory-result FIFO entries; power of two, >= 2.
- DROP_R0, 1, when 1, writes to address 0 are discarded and never reach the write port.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result present this cycle; always consumed.
- alu_addr  input  ADDR_WIDTH  ALU destination register.
- alu_data  input  DATA_WIDTH  ALU result.
- mem_valid  input  1  memory result offered.
- mem_ready  output  1  FIFO can accept; equals not-full.
- mem_addr  input  ADDR_WIDTH  memory destination register.
- mem_data  input  DATA_WIDTH  memory result.
- write_enable  output  1  registered; to register file write_enable.
- write_addr  output  ADDR_WIDTH  registered; to register file write_addr.
- write_data  output  DATA_WIDTH  registered; to register file write_data.
- busy_mask  output  2**ADDR_WIDTH  bit k set while a valid FIFO entry targets register k.
- fifo_count  output  $clog2(DEPTH)+1  number of queued memory results.

Behaviour:
- Reset (rst_n low, asynchronous):
  - write_enable=0, write_addr=0, write_data=0.
  - FIFO emptied, fifo_count=0, busy_mask=0, mem_ready=1.
- Reset mid-operation discards all queued results. No write is issued on the edge where rst_n deasserts.
- Accept and enqueue:
  - Memory accept occurs on a rising edge with mem_valid && mem_ready; entry {mem_addr, mem_data} is enqueued.
  - mem_ready depends only on registered state (fifo_count < DEPTH), never on mem_valid or alu_valid.
- Write-port arbitration, evaluated each edge:
  - If alu_valid: the output registers load {1, alu_addr, alu_data}. The FIFO is not dequeued.
  - Else if the FIFO is non-empty: the head is dequeued and loaded as {1, head_addr, head_data}.
  - Else: write_enable <= 0; write_addr and write_data hold their previous values.
- Latency:
  - ALU result presented in cycle N appears on the write port in cycle N+1 and is written into the register file at the end of N+1.
  - Memory result accepted at edge E is earliest dequeued at edge E+1. There is no bypass around the FIFO.
- DROP_R0=1: an ALU or memory entry with address 0 still wins arbitration (FIFO still dequeued), but write_enable is loaded as 0.
- Simultaneous enqueue and dequeue on the same edge: both happen; fifo_count is unchanged.
- Full FIFO: mem_ready=0; mem_valid is ignored, with no data loss and no overwrite. A dequeue on that edge makes mem_ready=1 in the next cycle.
- Pointers wrap modulo DEPTH.
- busy_mask:
  - Combinational OR over valid entries of one-hot(entry_addr); updates in the cycle after enqueue/dequeue.
  - The entry currently on the write port is no longer counted.
  - With DROP_R0=1, bit 0 is forced to 0.
- Ordering:
  - Memory results are written in acceptance order.
  - ALU vs memory ordering for the same register is not enforced here. The hazard unit uses busy_mask to avoid issuing an ALU op whose destination is busy.
- Starvation: continuous alu_valid stalls FIFO drain indefinitely. This is an accepted condition; the FIFO fills and backpressures via mem_ready.

Test Plan:
- Reset, then ALU alone: alu_valid=1, addr=3, data=0x1234 in cycle 1 -> cycle 2: write_enable=1, write_addr=3, write_data=0x1234; cycle 3: write_enable=0.
- Memory path: mem_valid=1, addr=7, data=0xDEADBEEF, accepted at edge 1, no ALU -> busy_mask[7]=1 and fifo_count=1 in cycle 1; write port shows addr 7 / 0xDEADBEEF in cycle 2; busy_mask=0 in cycle 2.
- Priority and backpressure:
  - Setup: alu_valid held high for 6 cycles while memory offers 5 results (addrs 1..5).
  - During the ALU burst: only ALU writes appear; mem_ready=0 after 4 accepts; 5th held.
  - After the burst: FIFO drains addrs 1,2,3,4 then 5 in order on consecutive cycles.
- Simultaneous enq/deq at full: FIFO full, no ALU, mem_valid=1 -> head dequeued, new entry not accepted that edge; accepted the next edge; fifo_count returns to 4.
- DROP_R0: ALU write addr 0 -> write_enable stays 0. Queued memory entry addr 0 -> dequeued, fifo_count decrements, no write issued, busy_mask[0]=0 throughout.
- Asynchronous reset mid-drain: 3 entries queued, rst_n pulsed low between edges -> outputs and fifo_count go to 0 immediately. After release, no stale write appears.
